// File: rtl/if_id_skid_if.sv
// IF/ID handshake bundle: the fetch/decode environment is the master,
// the skid stage is the slave.
interface if_id_skid_if #(
   parameter int IW = 32,
   parameter int AW = 32,
   parameter int CW = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] in_instr;
   logic [AW-1:0] in_pc;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_instr;
   logic [AW-1:0] out_pc_next;
   logic [AW-1:0] out_pc;
   logic [CW-1:0] stall_cnt;

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_instr, out_pc_next, out_pc, stall_cnt
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_instr, out_pc_next, out_pc, stall_cnt
   );
endinterface

// File: rtl/if_id_skid.sv
// IF/ID pipeline register built as a 2-entry skid buffer (main + skid)
// with flush, precomputed next PC and a saturating stall counter.
module if_id_skid #(
   parameter int            IW      = 32,
   parameter int            AW      = 32,
   parameter int            PC_STEP = 4,
   parameter logic [IW-1:0] NOP     = {IW{1'b0}},
   parameter int            CW      = 16
) (
   input logic          clock,
   input logic          reset_n,
   if_id_skid_if.slave  bus
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic          r_inReady;
   logic [IW-1:0] r_mainInstr;
   logic [AW-1:0] r_mainPc;
   logic [AW-1:0] r_mainPcNext;
   logic [IW-1:0] r_skidInstr;
   logic [AW-1:0] r_skidPc;
   logic [AW-1:0] r_skidPcNext;
   logic [CW-1:0] r_stallCnt;

   logic          w_outValid;
   logic          w_xferIn;
   logic          w_xferOut;
   logic          w_loadMain;
   logic          w_loadSkid;
   logic          w_skidToMain;
   logic [AW-1:0] w_inPcNext;

   // A flushed beat is never accepted, even though in_ready may be high.
   assign w_outValid = (r_state != EMPTY);
   assign w_xferIn   = bus.in_valid & r_inReady & ~bus.flush;
   assign w_xferOut  = w_outValid & bus.out_ready;
   assign w_inPcNext = bus.in_pc + AW'(PC_STEP);

   always_comb begin
      w_nextState  = r_state;
      w_loadMain   = 1'b0;
      w_loadSkid   = 1'b0;
      w_skidToMain = 1'b0;
      if (bus.flush) begin
         w_nextState = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_xferIn) begin
                  w_loadMain  = 1'b1;
                  w_nextState = ONE;
               end
            end
            ONE: begin
               if (w_xferIn && w_xferOut) begin
                  w_loadMain = 1'b1;
               end else if (w_xferIn) begin
                  w_loadSkid  = 1'b1;
                  w_nextState = FULL;
               end else if (w_xferOut) begin
                  w_nextState = EMPTY;
               end
            end
            FULL: begin
               if (w_xferOut) begin
                  w_skidToMain = 1'b1;
                  w_nextState  = ONE;
               end
            end
            default: w_nextState = EMPTY;
         endcase
      end
   end

   // in_ready is registered: it is simply "next state will not be FULL".
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= EMPTY;
         r_inReady <= 1'b1;
      end else begin
         r_state   <= w_nextState;
         r_inReady <= (w_nextState != FULL);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_mainInstr  <= NOP;
         r_mainPc     <= '0;
         r_mainPcNext <= '0;
      end else if (w_loadMain) begin
         r_mainInstr  <= bus.in_instr;
         r_mainPc     <= bus.in_pc;
         r_mainPcNext <= w_inPcNext;
      end else if (w_skidToMain) begin
         r_mainInstr  <= r_skidInstr;
         r_mainPc     <= r_skidPc;
         r_mainPcNext <= r_skidPcNext;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_skidInstr  <= NOP;
         r_skidPc     <= '0;
         r_skidPcNext <= '0;
      end else if (w_loadSkid) begin
         r_skidInstr  <= bus.in_instr;
         r_skidPc     <= bus.in_pc;
         r_skidPcNext <= w_inPcNext;
      end
   end

   // Stall accounting deliberately ignores flush.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_stallCnt <= '0;
      end else if (w_outValid && !bus.out_ready && (r_stallCnt != {CW{1'b1}})) begin
         r_stallCnt <= r_stallCnt + CW'(1);
      end
   end

   assign bus.in_ready    = r_inReady;
   assign bus.out_valid   = w_outValid;
   assign bus.out_instr   = w_outValid ? r_mainInstr : NOP;
   assign bus.out_pc      = r_mainPc;
   assign bus.out_pc_next = r_mainPcNext;
   assign bus.stall_cnt   = r_stallCnt;

endmodule

// File: tb/tb_if_id_skid.sv
// Directed bench for if_id_skid: vector table for streaming, backpressure,
// flush and PC wrap, plus hand sequences for async reset and saturation.
module tb_if_id_skid;

   logic clock;
   logic reset_n;
   int   checks;
   int   errors;

   if_id_skid_if #(.IW(32), .AW(32), .CW(16)) bus1 ();
   if_id_skid_if #(.IW(32), .AW(32), .CW(2))  bus2 ();

   if_id_skid #(.IW(32), .AW(32), .PC_STEP(4), .NOP(32'h0), .CW(16)) dut1 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus1.slave)
   );

   if_id_skid #(.IW(32), .AW(32), .PC_STEP(4), .NOP(32'h0), .CW(2)) dut2 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus2.slave)
   );

   typedef struct {
      logic        iv;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fl;
      logic        ordy;
      logic        eOv;
      logic        eIrdy;
      logic [31:0] eInstr;
      logic [31:0] ePc;
      logic [31:0] ePcn;
      logic [15:0] eSt;
   } vec_t;

   vec_t vecs [$];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mkVec(logic iv, logic [31:0] instr, logic [31:0] pc, logic fl,
                                  logic ordy, logic eOv, logic eIrdy, logic [31:0] eInstr,
                                  logic [31:0] ePc, logic [31:0] ePcn, logic [15:0] eSt);
      vec_t v;
      v.iv = iv; v.instr = instr; v.pc = pc; v.fl = fl; v.ordy = ordy;
      v.eOv = eOv; v.eIrdy = eIrdy; v.eInstr = eInstr;
      v.ePc = ePc; v.ePcn = ePcn; v.eSt = eSt;
      return v;
   endfunction

   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus1.in_valid  = v.iv;
      bus1.in_instr  = v.instr;
      bus1.in_pc     = v.pc;
      bus1.flush     = v.fl;
      bus1.out_ready = v.ordy;
   endtask

   task automatic checkOutput(input string tag, input vec_t v);
      checkValue({tag, ".out_valid"},   64'(bus1.out_valid),   64'(v.eOv));
      checkValue({tag, ".in_ready"},    64'(bus1.in_ready),    64'(v.eIrdy));
      checkValue({tag, ".out_instr"},   64'(bus1.out_instr),   64'(v.eInstr));
      checkValue({tag, ".out_pc"},      64'(bus1.out_pc),      64'(v.ePc));
      checkValue({tag, ".out_pc_next"}, 64'(bus1.out_pc_next), 64'(v.ePcn));
      checkValue({tag, ".stall_cnt"},   64'(bus1.stall_cnt),   64'(v.eSt));
   endtask

   initial begin
      vec_t rst;
      checks = 0;
      errors = 0;
      reset_n = 1'b0;
      bus1.in_valid = 1'b0; bus1.in_instr = '0; bus1.in_pc = '0; bus1.flush = 1'b0; bus1.out_ready = 1'b0;
      bus2.in_valid = 1'b0; bus2.in_instr = '0; bus2.in_pc = '0; bus2.flush = 1'b0; bus2.out_ready = 1'b0;

      // streaming
      vecs.push_back(mkVec(1, 32'hA000_0001, 32'h0,  0, 1,  1, 1, 32'hA000_0001, 32'h0,  32'h4,  0));
      vecs.push_back(mkVec(1, 32'hA000_0002, 32'h4,  0, 1,  1, 1, 32'hA000_0002, 32'h4,  32'h8,  0));
      vecs.push_back(mkVec(1, 32'hA000_0003, 32'h8,  0, 1,  1, 1, 32'hA000_0003, 32'h8,  32'hC,  0));
      vecs.push_back(mkVec(1, 32'hA000_0004, 32'hC,  0, 1,  1, 1, 32'hA000_0004, 32'hC,  32'h10, 0));
      vecs.push_back(mkVec(0, 32'h0,         32'h0,  0, 1,  0, 1, 32'h0,         32'hC,  32'h10, 0));
      // backpressure
      vecs.push_back(mkVec(1, 32'hB000_0001, 32'h100, 0, 0, 1, 1, 32'hB000_0001, 32'h100, 32'h104, 0));
      vecs.push_back(mkVec(1, 32'hB000_0002, 32'h104, 0, 0, 1, 0, 32'hB000_0001, 32'h100, 32'h104, 1));
      vecs.push_back(mkVec(1, 32'hB000_0003, 32'h108, 0, 0, 1, 0, 32'hB000_0001, 32'h100, 32'h104, 2));
      vecs.push_back(mkVec(1, 32'hB000_0003, 32'h108, 0, 0, 1, 0, 32'hB000_0001, 32'h100, 32'h104, 3));
      vecs.push_back(mkVec(0, 32'h0,         32'h0,   0, 1, 1, 1, 32'hB000_0002, 32'h104, 32'h108, 3));
      vecs.push_back(mkVec(0, 32'h0,         32'h0,   0, 1, 0, 1, 32'h0,         32'h104, 32'h108, 3));
      // flush while FULL, then flush while EMPTY with a beat offered
      vecs.push_back(mkVec(1, 32'hC000_0001, 32'h200, 0, 0, 1, 1, 32'hC000_0001, 32'h200, 32'h204, 3));
      vecs.push_back(mkVec(1, 32'hC000_0002, 32'h204, 0, 0, 1, 0, 32'hC000_0001, 32'h200, 32'h204, 4));
      vecs.push_back(mkVec(1, 32'hC000_0003, 32'h208, 1, 0, 0, 1, 32'h0,         32'h200, 32'h204, 5));
      vecs.push_back(mkVec(0, 32'h0,         32'h0,   0, 1, 0, 1, 32'h0,         32'h200, 32'h204, 5));
      vecs.push_back(mkVec(1, 32'hC000_0004, 32'h20C, 1, 1, 0, 1, 32'h0,         32'h200, 32'h204, 5));
      // PC wrap
      vecs.push_back(mkVec(1, 32'hD000_0001, 32'hFFFF_FFFC, 0, 1, 1, 1, 32'hD000_0001, 32'hFFFF_FFFC, 32'h0, 5));
      vecs.push_back(mkVec(1, 32'hD000_0002, 32'h300, 0, 1, 1, 1, 32'hD000_0002, 32'h300, 32'h304, 5));
      vecs.push_back(mkVec(0, 32'h0,         32'h0,   0, 1, 0, 1, 32'h0,         32'h300, 32'h304, 5));

      @(negedge clock);
      @(negedge clock);
      rst = mkVec(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0);
      checkOutput("reset", rst);

      reset_n = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         @(negedge clock);
         checkOutput($sformatf("vec%0d", i), vecs[i]);
      end

      // fill to FULL, then assert reset mid-cycle
      bus1.in_valid = 1'b1; bus1.in_instr = 32'hE000_0001; bus1.in_pc = 32'h400;
      bus1.flush = 1'b0; bus1.out_ready = 1'b0;
      @(negedge clock);
      bus1.in_instr = 32'hE000_0002; bus1.in_pc = 32'h404;
      @(negedge clock);
      checkValue("full.out_valid", 64'(bus1.out_valid), 64'd1);
      checkValue("full.in_ready",  64'(bus1.in_ready),  64'd0);
      #2;
      reset_n = 1'b0;
      #1;
      rst = mkVec(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0);
      checkOutput("asyncrst", rst);
      bus1.in_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      checkValue("release.in_ready",  64'(bus1.in_ready),  64'd1);
      checkValue("release.out_valid", 64'(bus1.out_valid), 64'd0);

      // saturation on the 2-bit counter instance
      bus2.in_valid = 1'b1; bus2.in_instr = 32'hF000_0001; bus2.in_pc = 32'h500; bus2.out_ready = 1'b0;
      @(negedge clock);
      checkValue("sat.out_valid", 64'(bus2.out_valid), 64'd1);
      checkValue("sat.out_instr", 64'(bus2.out_instr), 64'hF000_0001);
      checkValue("sat.stall0",    64'(bus2.stall_cnt), 64'd0);
      bus2.in_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         checkValue($sformatf("sat.stall%0d", k), 64'(bus2.stall_cnt), 64'((k < 3) ? k : 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 Parameter IW, default 32, instruction width in bits.
REQ-002 Parameter AW, default 32, PC width in bits.
REQ-003 Parameter PC_STEP, default 4, increment added to the incoming PC.
REQ-004 Parameter NOP, default {IW{1'b0}}, instruction value driven when the stage holds no valid instruction.
REQ-005 Parameter CW, default 16, stall-counter width.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clock  in  1  rising-edge clock.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 in_valid  in  1  fetch presents an instruction.
REQ-010 in_ready  out  1  stage can accept; equals NOT skid_valid, registered.
REQ-011 in_instr  in  IW  fetched instruction.
REQ-012 in_pc  in  AW  PC of the fetched instruction.
REQ-013 flush  in  1  discard all held and incoming instructions (branch taken).
REQ-014 out_valid  out  1  decode-side instruction valid.
REQ-015 out_ready  in  1  decode accepts the current output.
REQ-016 out_instr  out  IW  held instruction, or NOP when out_valid=0.
REQ-017 out_pc_next  out  AW  held in_pc + PC_STEP.
REQ-018 out_pc  out  AW  held in_pc, unmodified.
REQ-019 stall_cnt  out  CW  saturating count of stalled cycles.

Function
REQ-020 The block SHALL implement a 2-entry skid buffer (main, skid) with states EMPTY (none valid), ONE (main valid), FULL (main and skid valid).
REQ-021 Transfer-in SHALL be in_valid AND in_ready; transfer-out SHALL be out_valid AND out_ready.
REQ-022 Outputs SHALL be driven only from the main entry; out_valid SHALL be 1 in states ONE and FULL.
REQ-023 EMPTY: on transfer-in, load main and go to ONE.
REQ-024 ONE: transfer-in with transfer-out SHALL reload main and stay in ONE; transfer-in only SHALL load skid and go to FULL; transfer-out only SHALL go to EMPTY.
REQ-025 FULL: in_ready=0; on transfer-out, skid SHALL move to main and the state SHALL go to ONE; otherwise hold.
REQ-026 Latency SHALL be 1 cycle from transfer-in to out_valid when the stage is empty; the block SHALL sustain full throughput of one instruction per cycle.
REQ-027 pc_next SHALL be computed at capture as (in_pc + PC_STEP) mod 2^AW, so 0xFFFFFFFC+4 gives 0x00000000.
REQ-028 flush SHALL have priority over everything: the next state is EMPTY, the incoming beat is dropped, and out_instr becomes NOP.
REQ-029 in_ready SHALL be 1 in the cycle after a flush.
REQ-030 When out_valid=0, out_instr SHALL equal NOP; out_pc and out_pc_next SHALL hold their last values.
REQ-031 stall_cnt SHALL increment each cycle with out_valid=1 and out_ready=0, saturate at 2^CW-1, and never wrap.
REQ-032 stall_cnt SHALL be unaffected by flush.
REQ-033 Data SHALL never be duplicated, reordered or lost except on flush.

Reset
REQ-034 While reset_n=0, asynchronously: state=EMPTY, out_valid=0, in_ready=1, out_instr=NOP, out_pc=0, out_pc_next=0, stall_cnt=0.
REQ-035 Reset asserted in the middle of operation SHALL discard both entries immediately, with no output glitch to a valid instruction.
REQ-036 Deassertion of reset_n SHALL take effect at the next clock edge; the first transfer-in is accepted on the first edge after deassertion.

Verification
REQ-037 Streaming: in_valid=1 and out_ready=1 with PCs 0, 4, 8, 12 -> out_pc_next is 4, 8, 12, 16 on consecutive cycles; stall_cnt stays 0.
REQ-038 Backpressure: out_ready=0 for 3 cycles while two beats are offered -> FULL, in_ready=0, stall_cnt=3; on release the two beats emerge in order with no loss.
REQ-039 Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_instr=NOP, in_ready=1; the dropped instructions never appear.
REQ-040 Wrap: in_pc=0xFFFFFFFC -> out_pc_next=0x00000000 and out_pc=0xFFFFFFFC.
REQ-041 Saturation with CW=2: 6 stalled cycles -> stall_cnt=3 and holds at 3.
REQ-042 Asynchronous reset mid-clock in FULL -> all outputs take reset values before the next edge; after release, in_ready=1.
